// File: rtl/uart_tx_frame_ctrl_if.sv
// Handshake bundle between the TX data source, the frame controller and the TX output mux.
// The master side supplies the payload; the slave side (frame controller) drives the mux controls.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [2:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; one line bit per clock.
// Drives the output-mux select plus the serial data and parity bits the mux routes to the line.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_frame_ctrl_if.slave tx
);
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [2:0] SEL_START  = 3'b000;
  localparam logic [2:0] SEL_STOP   = 3'b001;
  localparam logic [2:0] SEL_DATA   = 3'b010;
  localparam logic [2:0] SEL_PARITY = 3'b011;
  localparam logic [2:0] SEL_IDLE   = 3'b100;

  logic [2:0]            state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  par_en_reg;
  logic                  par_bit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Parity is fixed at acceptance so later input changes cannot disturb the frame.
          if (tx.data_valid) begin
            shift_reg   <= tx.p_data;
            par_en_reg  <= tx.par_en;
            par_bit_reg <= (^tx.p_data) ^ tx.par_typ;
            cnt_reg     <= '0;
            state_reg   <= ST_START;
          end
        end
        ST_START: state_reg <= ST_DATA;
        ST_DATA: begin
          shift_reg <= shift_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: state_reg <= ST_STOP;
        ST_STOP:   state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx.mux_sel = SEL_IDLE;
    tx.busy    = 1'b1;
    case (state_reg)
      ST_START:  tx.mux_sel = SEL_START;
      ST_DATA:   tx.mux_sel = SEL_DATA;
      ST_PARITY: tx.mux_sel = SEL_PARITY;
      ST_STOP:   tx.mux_sel = SEL_STOP;
      default: begin
        tx.mux_sel = SEL_IDLE;
        tx.busy    = 1'b0;
      end
    endcase
  end

  assign tx.ser_data = shift_reg[0];
  assign tx.par_bit  = par_bit_reg;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed frames plus randomized frames,
// each cycle compared against a per-frame expectation built from the frame layout.
module tb_uart_tx_frame_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(W)) tx_if ();

  uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_mux"}, 32'(tx_if.mux_sel), 32'd4);
    check_val({tag, "_busy"}, 32'(tx_if.busy), 32'd0);
  endtask

  // Sends one frame starting from an IDLE cycle (called at posedge+1) and checks every
  // cycle of it. The expected line layout is derived from the frame structure only:
  // cycle 0 start, cycles 1..W data LSB first, then optional parity, then stop.
  task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                           input bit hold, input bit noise, input int abort_at);
    logic       exp_par;
    logic [2:0] exp_mux;
    int         n;
    exp_par = (^d) ^ pt;
    n       = W + (pe ? 3 : 2);
    tx_if.p_data     = d;
    tx_if.par_en     = pe;
    tx_if.par_typ    = pt;
    tx_if.data_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) tx_if.data_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c == 0)                exp_mux = 3'b000;
      else if (c <= W)           exp_mux = 3'b010;
      else if (c == W + 1 && pe) exp_mux = 3'b011;
      else                       exp_mux = 3'b001;
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_val("abort_mux", 32'(tx_if.mux_sel), 32'd4);
        check_val("abort_busy", 32'(tx_if.busy), 32'd0);
        check_val("abort_ser", 32'(tx_if.ser_data), 32'd0);
        check_val("abort_par", 32'(tx_if.par_bit), 32'd0);
        tx_if.data_valid = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("post_abort");
        $display("[TB] frame d=%02h pe=%0b pt=%0b aborted at cycle %0d", d, pe, pt, c);
        return;
      end
      check_val($sformatf("mux_c%0d", c), 32'(tx_if.mux_sel), 32'(exp_mux));
      check_val($sformatf("busy_c%0d", c), 32'(tx_if.busy), 32'd1);
      check_val($sformatf("par_c%0d", c), 32'(tx_if.par_bit), 32'(exp_par));
      if (c >= 1 && c <= W)
        check_val($sformatf("ser_c%0d", c), 32'(tx_if.ser_data), 32'(d[c-1]));
      if (noise && c == 3) begin
        tx_if.p_data     = ~d;
        tx_if.par_typ    = ~pt;
        tx_if.par_en     = ~pe;
        tx_if.data_valid = 1'b1;
      end
      if (noise && c == 5) tx_if.data_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_idle("after_frame");
    $display("[TB] frame d=%02h pe=%0b pt=%0b len=%0d par=%0b checked", d, pe, pt, n, exp_par);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check_idle("gap");
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    tx_if.p_data     = '0;
    tx_if.data_valid = 1'b0;
    tx_if.par_en     = 1'b0;
    tx_if.par_typ    = 1'b0;
    #2;
    check_val("rst_mux", 32'(tx_if.mux_sel), 32'd4);
    check_val("rst_busy", 32'(tx_if.busy), 32'd0);
    check_val("rst_ser", 32'(tx_if.ser_data), 32'd0);
    check_val("rst_par", 32'(tx_if.par_bit), 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("post_reset");

    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(2);
    // Inputs disturbed mid-frame: 0x55 with its original parity must still go out.
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle_cycles(1);
    // Back-to-back with valid held: each frame ends in exactly one checked idle cycle.
    for (int i = 0; i < 3; i++) run_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    tx_if.data_valid = 1'b0;
    idle_cycles(1);
    // Abort during data bit 3, then a clean frame.
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      run_frame(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), -1);
      idle_cycles($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
